// File: rtl/fifo_nibble_packer.sv
// Drains a 4-bit synchronous FIFO two nibbles at a time, packs each pair into a byte
// and offers it on a valid/ready port; flush emits a lone held nibble when the FIFO runs dry.
module fifo_nibble_packer #(
    parameter int LOW_FIRST = 1,
    parameter int CNT_W     = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_fifo_empty,
    input  logic [3:0]       i_fifo_data,
    output logic             o_fifo_rd_en,
    input  logic             i_flush,
    output logic [7:0]       o_byte_out,
    output logic             o_byte_valid,
    input  logic             i_byte_ready,
    output logic             o_partial,
    output logic [CNT_W-1:0] o_byte_count
);

    typedef enum logic [2:0] {
        FETCH0 = 3'd0,
        CAP0   = 3'd1,
        FETCH1 = 3'd2,
        CAP1   = 3'd3,
        OUT    = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [3:0]       r_hold;
    logic [7:0]       r_byte;
    logic             r_valid;
    logic             r_partial;
    logic [CNT_W-1:0] r_count;
    logic             w_pop_zone;
    logic             w_flush_go;
    logic             w_handshake;

    function automatic logic [7:0] pack(input logic [3:0] first, input logic [3:0] second);
        if (LOW_FIRST != 0) begin
            return {second, first};
        end
        return {first, second};
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= FETCH0;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_pop_zone   = (r_state == FETCH0) || (r_state == CAP0) || (r_state == FETCH1);
        // Gated by reset so no pop can be requested while the block is held in reset.
        o_fifo_rd_en = w_pop_zone && !i_fifo_empty && i_rst_n;
        w_flush_go   = (r_state == FETCH1) && i_fifo_empty && i_flush;
        w_handshake  = r_valid && i_byte_ready;
        case (r_state)
            FETCH0: begin
                if (!i_fifo_empty) begin
                    w_next = CAP0;
                end
            end
            CAP0: begin
                w_next = i_fifo_empty ? FETCH1 : CAP1;
            end
            FETCH1: begin
                if (!i_fifo_empty) begin
                    w_next = CAP1;
                end else if (i_flush) begin
                    w_next = OUT;
                end
            end
            CAP1: begin
                w_next = OUT;
            end
            OUT: begin
                if (w_handshake) begin
                    w_next = FETCH0;
                end
            end
            default: begin
                w_next = FETCH0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hold    <= 4'h0;
            r_byte    <= 8'h00;
            r_valid   <= 1'b0;
            r_partial <= 1'b0;
            r_count   <= '0;
        end else begin
            case (r_state)
                CAP0: begin
                    r_hold    <= i_fifo_data;
                    r_partial <= 1'b1;
                end
                FETCH1: begin
                    // A lone nibble takes the first slot; partial stays up until it is accepted.
                    if (w_flush_go) begin
                        r_byte  <= pack(r_hold, 4'h0);
                        r_valid <= 1'b1;
                    end
                end
                CAP1: begin
                    r_byte    <= pack(r_hold, i_fifo_data);
                    r_valid   <= 1'b1;
                    r_partial <= 1'b0;
                end
                OUT: begin
                    if (w_handshake) begin
                        r_valid   <= 1'b0;
                        r_partial <= 1'b0;
                        r_count   <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_byte_out   = r_byte;
    assign o_byte_valid = r_valid;
    assign o_partial    = r_partial;
    assign o_byte_count = r_count;

endmodule

// File: doc/fifo_nibble_packer.md
# fifo_nibble_packer

Downstream drain stage for the 4-bit, 8-deep synchronous FIFO. It pops nibbles through the FIFO's read port and packs each pair into one byte. It presents that byte on a valid/ready output handshake and keeps a running byte count. A flush input emits a half-filled byte when the FIFO runs dry mid-pair.

## Interface
- LOW_FIRST, 1, 1: first popped nibble goes to byte_out[3:0], second to [7:4]; 0: first goes to [7:4], second to [3:0]
- CNT_W, 8, width of byte_count
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- fifo_empty  input  1  FIFO empty flag, combinational from the FIFO pointers
- fifo_data  input  4  FIFO data_out; registered, valid the cycle after a pop
- fifo_rd_en  output  1  pop request to the FIFO
- flush  input  1  emit the pending half byte if the FIFO is empty
- byte_out  output  8  packed byte
- byte_valid  output  1  byte_out is valid
- byte_ready  input  1  consumer accepts byte_out
- partial  output  1  one nibble is held and its pair is not yet popped
- byte_count  output  CNT_W  number of completed handshakes, modulo 2^CNT_W

## Operation
- Clocking and reset: one clock (clk). reset is asynchronous and active-low.
- Reset state and outputs:
  - state is FETCH0.
  - byte_out, byte_valid, partial and byte_count are all 0.
  - The nibble holding register is cleared.
  - fifo_rd_en is forced to 0 while reset is low.
- The FIFO pop contract:
  - A pop takes effect only when fifo_rd_en = 1 and fifo_empty = 0 at a rising edge.
  - fifo_data is captured on the following edge.
  - fifo_rd_en = (state is FETCH0, CAP0 or FETCH1) and not fifo_empty. It is combinational.
- FETCH0: if fifo_rd_en pops, go to CAP0; otherwise stay.
- CAP0:
  - Capture fifo_data into the nibble holding register and set partial = 1.
  - If the FIFO is non-empty, the second pop is issued in this same cycle and the next state is CAP1.
  - Otherwise the next state is FETCH1.
- FETCH1 (partial = 1):
  - If the FIFO is non-empty, pop and go to CAP1. A pop has priority over flush.
  - If the FIFO is empty and flush = 1, load byte_out with the held nibble in its first slot and 0 in the other. Set byte_valid and go to OUT.
  - Otherwise stay.
- CAP1:
  - Load byte_out with the held nibble and fifo_data, placed according to LOW_FIRST.
  - Set byte_valid = 1, clear partial, go to OUT.
- OUT:
  - byte_out and byte_valid hold steady until byte_valid and byte_ready are both 1 at an edge.
  - On that edge, clear byte_valid, increment byte_count and go to FETCH0.
  - No pops are issued in OUT.
- flush is ignored in every state except FETCH1 with the FIFO empty.
- byte_count wraps from 2^CNT_W - 1 to 0.
- Reset asserted mid-operation: all state is abandoned immediately. Any held nibble and any unaccepted byte are discarded, not emitted.
- byte_out is don't-care while byte_valid = 0, but it retains its last value; it is not cleared.

## Timing
- Pop-to-capture latency: 1 cycle, matching the FIFO's registered read.
- Minimum latency with a continuously non-empty FIFO and byte_ready held high:
  - edge 1: FETCH0 pops the low nibble.
  - edge 2: CAP0 captures it and pops again.
  - edge 3: CAP1 assembles the byte.
  - byte_valid is high in the cycle after edge 3.
  - The handshake occurs at edge 4.
- Throughput: one byte per 4 cycles maximum.
- byte_ready low stalls the block in OUT indefinitely. byte_out must be stable throughout the stall and no FIFO reads are issued.
- Flush path: flush is sampled at edge N while in FETCH1 with the FIFO empty. byte_valid goes high after edge N.
- Empty in the same cycle as a would-be pop: no pop occurs and the state holds.

## Test plan
- Reset mid-stream: assert reset in CAP1 -> all outputs 0 and state FETCH0 immediately; the next pair popped after release is packed cleanly.
- Basic pack, LOW_FIRST=1: FIFO holds 0xA then 0x5, byte_ready = 1 -> fifo_rd_en high on 2 consecutive cycles; byte_out = 0x5A with byte_valid for 1 cycle; byte_count = 1.
- Order, LOW_FIRST=0: same stimulus -> byte_out = 0xA5.
- Backpressure: hold byte_ready = 0 for 10 cycles with 0x3, 0xC queued -> byte_out = 0xC3 stable for 10 cycles; fifo_rd_en stays 0; a single increment on release.
- Flush: single nibble 0x7 is popped and the FIFO is left empty; partial = 1; then flush = 1 -> byte_out = 0x07 (LOW_FIRST=1); partial clears after the handshake. Also: flush arriving together with a late 0x2 write -> byte_out = 0x27, no flush byte.
- Drain full FIFO: 7 nibbles (0x1 to 0x7) then flush, byte_ready toggling -> bytes 0x21, 0x43, 0x65, 0x07; byte_count = 4; fifo_empty stays 1 and there are no further pops. With CNT_W=2, byte_count wraps 3 -> 0.
